// File: rtl/gp_serial_adder_ctrl.sv
// Bit-serial adder: one generate/propagate cell walks the operands LSB-first,
// one bit per clock, and registers sum/carry/overflow/group G,P on completion.
module gp_serial_adder_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             grp_g,
   output logic             grp_p
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_psum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_gacc;
   logic             r_pacc;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_grp_g;
   logic             r_grp_p;

   logic             w_gi;
   logic             w_pi;
   logic             w_carry_next;
   logic             w_gacc_next;
   logic             w_pacc_next;
   logic [WIDTH-1:0] w_psum_next;
   logic             w_last;

   assign w_gi         = r_a_sr[0] & r_b_sr[0];
   assign w_pi         = r_a_sr[0] ^ r_b_sr[0];
   assign w_carry_next = w_gi | (w_pi & r_carry);
   assign w_gacc_next  = w_gi | (w_pi & r_gacc);
   assign w_pacc_next  = r_pacc & w_pi;
   assign w_psum_next  = {w_pi ^ r_carry, r_psum[WIDTH-1:1]};
   assign w_last       = (r_state == S_RUN) && (r_cnt == LAST_BIT);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (r_cnt == LAST_BIT) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_psum  <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_gacc  <= 1'b0;
         r_pacc  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_grp_g <= 1'b0;
         r_grp_p <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_psum  <= '0;
                  r_gacc  <= 1'b0;
                  r_pacc  <= 1'b1;
               end
            end
            S_RUN: begin
               r_a_sr  <= r_a_sr >> 1;
               r_b_sr  <= r_b_sr >> 1;
               r_psum  <= w_psum_next;
               r_carry <= w_carry_next;
               r_gacc  <= w_gacc_next;
               r_pacc  <= w_pacc_next;
               r_cnt   <= r_cnt + CW'(1);
               // r_carry here is still the carry into the MSB
               if (w_last) begin
                  r_sum   <= w_psum_next;
                  r_cout  <= w_carry_next;
                  r_ovf   <= r_carry ^ w_carry_next;
                  r_grp_g <= w_gacc_next;
                  r_grp_p <= w_pacc_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (r_state != S_IDLE);
   assign done  = (r_state == S_DONE);
   assign sum   = r_sum;
   assign cout  = r_cout;
   assign ovf   = r_ovf;
   assign grp_g = r_grp_g;
   assign grp_p = r_grp_p;

endmodule

// File: tb/tb_gp_serial_adder_ctrl.sv
// Bench for gp_serial_adder_ctrl: vector table plus sequencing/reset corner cases,
// results checked through an expected-result queue popped on each done pulse.
module tb_gp_serial_adder_ctrl;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         g;
      logic         p;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout, ovf, grp_g, grp_p;
   logic [W-1:0] sum;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   vec_t exp_q[$];

   gp_serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
      .grp_g(grp_g), .grp_p(grp_p)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
      vec_t v;
      logic [W:0] full, nocin;
      full  = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
      nocin = {1'b0, va} + {1'b0, vb};
      v.a = va; v.b = vb; v.cin = vc;
      v.sum  = full[W-1:0];
      v.cout = full[W];
      v.ovf  = (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1]);
      v.g    = nocin[W];
      v.p    = &(va ^ vb);
      return v;
   endfunction

   // Scoreboard: every done pops one expected result
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            vec_t e;
            e = exp_q.pop_front();
            $display("done: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d g=%0d p=%0d",
                     e.a, e.b, e.cin, sum, cout, ovf, grp_g, grp_p);
            chk("sum",   32'(sum),   32'(e.sum));
            chk("cout",  32'(cout),  32'(e.cout));
            chk("ovf",   32'(ovf),   32'(e.ovf));
            chk("grp_g", 32'(grp_g), 32'(e.g));
            chk("grp_p", 32'(grp_p), 32'(e.p));
         end
      end
   end

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle
   task automatic do_add(input vec_t v);
      a = v.a; b = v.b; cin = v.cin; start = 1'b1;
      exp_q.push_back(v);
      @(negedge clk);
      start = 1'b0;
      wait_done("add");
      @(negedge clk);
   endtask

   vec_t tbl[6];

   initial begin
      int k, done_at, busy_cnt, t1, t2;
      vec_t v;

      tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      chk("reset_outs", 32'({busy, done, cout, ovf, grp_g, grp_p, sum}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Latency of the first vector: done on the 9th negedge after start, 9 busy cycles
      a = tbl[0].a; b = tbl[0].b; cin = tbl[0].cin; start = 1'b1;
      exp_q.push_back(tbl[0]);
      done_at = 0; busy_cnt = 0; k = 0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (busy) busy_cnt++;
         if (done && done_at == 0) done_at = i;
         @(negedge clk);
      end
      chk("done_latency", 32'(done_at), 32'd9);
      chk("busy_cycles", 32'(busy_cnt), 32'd9);

      for (int i = 1; i < 6; i++) do_add(tbl[i]);
      for (int i = 0; i < 4; i++) do_add(model(W'($urandom), W'($urandom), 1'($urandom)));

      // Back-to-back with start held high
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      exp_q.push_back('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      a = 8'hF0; b = 8'h0F;
      exp_q.push_back('{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
      wait_done("b2b_1");
      t1 = cyc;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done("b2b_2");
      t2 = cyc;
      chk("b2b_spacing", 32'(t2 - t1), 32'd10);
      @(negedge clk);

      // start toggling and operand changes during RUN must be ignored
      v = '{8'h55, 8'h33, 1'b0, 8'h88, 1'b0, 1'b1, 1'b0, 1'b0};
      a = v.a; b = v.b; cin = v.cin; start = 1'b1;
      exp_q.push_back(v);
      @(negedge clk);
      start = 1'b0;
      chk("hold_prev_sum", 32'(sum), 32'hFF);
      for (int i = 0; i < 6; i++) begin
         start = ~start; a = W'($urandom); b = W'($urandom); cin = ~cin;
         @(negedge clk);
      end
      start = 1'b0;
      wait_done("toggle");
      repeat (15) @(negedge clk);
      chk("toggle_idle", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of RUN
      a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("abort_outs", 32'({busy, done, cout, ovf, grp_g, grp_p, sum}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_no_done", 32'(exp_q.size()), 32'd0);
      do_add('{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0, 1'b0, 1'b0});

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gp_serial_adder_ctrl.md
Name: gp_serial_adder_ctrl

Overview:
- Bit-serial multi-bit adder controller built around one single-bit generate/propagate cell (Gi = a&b, Pi = a^b).
- Sequences WIDTH operand bits through the cell LSB-first, one bit per clock. Carries Ci+1 = Gi | Pi&Ci between cycles.
- Accumulates group generate/propagate and signed overflow.
- Used where a full ripple/CLA adder is too large and WIDTH+2 cycles per add is acceptable.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width (derived).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; results valid from this cycle.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of MSB.
- ovf  output  1  signed overflow = carry into MSB ^ carry out of MSB.
- grp_g  output  1  group generate over all WIDTH bits (independent of cin).
- grp_p  output  1  group propagate = AND of all Pi.

Behaviour:
- Reset: rst_n low forces state IDLE immediately, regardless of clk. Outputs busy=0, done=0, sum=0, cout=0, ovf=0, grp_g=0, grp_p=0. Internal operand, carry and counter registers clear. Reset mid-RUN aborts the add with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start=1.
  - Capture a, b into shift registers and cin into the carry register.
  - Counter <= 0; partial-sum register <= 0; gacc <= 0; pacc <= 1.
- RUN, each edge:
  - Compute gi = a_sr[0]&b_sr[0], pi = a_sr[0]^b_sr[0].
  - Shift pi^carry into the partial-sum MSB while the partial-sum register shifts right.
  - carry <= gi | pi&carry.
  - gacc <= gi | pi&gacc.
  - pacc <= pacc & pi.
  - Shift a_sr and b_sr right; counter++.
  - At the counter==WIDTH-1 edge, also latch carry-into-MSB (the current carry register) for ovf.
- RUN -> DONE: on the edge processing bit WIDTH-1.
  - Output registers load: sum <= final partial sum, cout <= final carry, ovf <= carry-into-MSB ^ final carry, grp_g <= final gacc, grp_p <= final pacc.
  - done=1 for the DONE cycle only.
- DONE -> IDLE: unconditionally on the next edge; done returns to 0.
- Latency:
  - Start sampled at edge 0; bits processed at edges 1..WIDTH; done high in the cycle after edge WIDTH.
  - Minimum start-to-start period is WIDTH+2 cycles.
- Output stability: sum/cout/ovf/grp_g/grp_p change only on the RUN->DONE edge or reset. They hold the previous result through IDLE and the entire next RUN.
- start in RUN or DONE is ignored and not queued. Operand and cin changes after capture have no effect.
- start held high continuously causes back-to-back adds, each re-capturing the current a/b/cin in IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. ovf interprets operands as two's complement. grp_g/grp_p are those of the whole WIDTH-bit group (grp_g | grp_p&cin == cout).

Test Plan:
- WIDTH=8: a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, ovf=0, grp_g=0, grp_p=0. done high exactly in the cycle after the 9th rising edge counted from the start edge (edge 0); busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0, grp_g=1, grp_p=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
- a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1, grp_p=1, grp_g=0.
  - Repeat with cin=0 -> sum=0xFF, cout=0.
- Sequencing:
  - start held high across two operand sets (0x12+0x34 then 0xF0+0x0F) -> sum=0x46 then 0xFF, with done pulses 10 cycles apart.
  - Toggle start during RUN -> no extra result.
  - Pull rst_n low at RUN bit 4 -> all outputs 0 immediately, no done; a subsequent start completes correctly.
